cam_ctrl: RTL and testbench
===========================

# cam_ctrl

Sequencing controller for the 9T SRAM content-addressable memory array. It accepts write, search and clear commands from a host over a valid/ready handshake. It drives the per-row write word lines and the differential data lines (DL/DLB) during writes, and the match-line precharge and differential search lines during searches. It keeps a valid bit per row, samples the array match lines, and returns a priority-encoded hit address. It sits between the mobile-SoC bus interface and the analog CAM array macro.

## Interface
Parameters:
- WORDS, 8, number of CAM rows; must be a power of two; AW = $clog2(WORDS)
- WIDTH, 4, bits per CAM word
- WR_CYC, 2, cycles WLWR is held high per write (>=1)
- PRE_CYC, 2, match-line precharge cycles (>=1)
- EVAL_CYC, 1, search-line evaluation cycles before the match lines are sampled (>=1)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  host command valid
- req_ready  out  1  controller idle and able to accept a command
- req_op  in  2  01 = write, 10 = search, 11 = clear all; 00 is a no-op that is accepted and gets no response
- req_addr  in  AW  write row address
- req_data  in  WIDTH  write data or search key
- resp_valid  out  1  one-cycle response strobe for write, search and clear
- resp_hit  out  1  search found at least one valid matching row
- resp_multi  out  1  search found more than one valid matching row
- resp_addr  out  AW  lowest matching row index; 0 when no hit
- wlwr  out  WORDS  one-hot row write word line
- dl  out  WIDTH  true data lines
- dlb  out  WIDTH  complement data lines
- sl  out  WIDTH  true search lines
- slb  out  WIDTH  complement search lines
- ml_pre  out  1  match-line precharge enable
- ml  in  WORDS  match lines from the array; 1 = row matches

## Operation
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, S_PRE, S_EVAL, S_CAPT, DONE.
- req_ready = 1 only in IDLE and while rst is low. A command is accepted on an edge with req_valid & req_ready.
- On acceptance, op/addr/data are latched. Input changes after acceptance are ignored.
- Write path: WR_SETUP → WR_PULSE (WR_CYC cycles) → WR_HOLD → DONE.
  - dl = data and dlb = ~data from WR_SETUP through WR_HOLD; otherwise both are 0.
  - wlwr[addr] = 1 only in WR_PULSE; all other wlwr bits stay 0.
  - valid[addr] is set on the edge leaving WR_HOLD.
- Search path: S_PRE (PRE_CYC cycles) → S_EVAL (EVAL_CYC cycles) → S_CAPT → DONE.
  - ml_pre = 1 only in S_PRE.
  - sl = slb = 0 in S_PRE. In S_EVAL and S_CAPT, sl = key and slb = ~key. Both are 0 elsewhere.
  - In S_CAPT, m = ml & valid is registered.
  - hit = |m. addr = lowest set index of m. multi = more than one bit of m set.
- Clear: all valid bits are cleared on the accepting edge; next state is DONE. wlwr, dl, dlb, sl, slb and ml_pre are never asserted.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_hit/resp_multi/resp_addr hold their values until the next search's DONE.
  - Write and clear do not modify them.
- Invariants:
  - wlwr and ml_pre are never both high.
  - sl/slb are never driven while ml_pre = 1.
  - dl and dlb are never both 1.
- Reset:
  - All outputs go to 0 except req_ready, which is 0 during rst and 1 the cycle after.
  - state = IDLE and valid = 0.
  - Reset mid-operation aborts on the same edge: wlwr drops, no response is issued, and a partially written row stays invalid.

## Timing
- Cycle 0 is the cycle after the accepting edge.
- Write (defaults): WR_SETUP at cycle 0; WR_PULSE at cycles 1..WR_CYC; WR_HOLD at WR_CYC+1; DONE at WR_CYC+2 (cycle 4). req_ready returns at WR_CYC+3.
- Search (defaults): S_PRE at cycles 0..PRE_CYC-1; S_EVAL at PRE_CYC..PRE_CYC+EVAL_CYC-1; S_CAPT at PRE_CYC+EVAL_CYC (cycle 3, ml sampled at the end of this cycle); DONE at cycle 4.
- Clear: DONE at cycle 0.
- Back-to-back: the minimum command spacing is the latency plus the IDLE cycle. req_valid held high is accepted again in the first IDLE cycle.
- The registered ml value is used; ml is don't-care outside S_CAPT.

## Test plan
- Reset then idle → all outputs 0, req_ready = 1 the cycle after rst falls; search key 4'h5 → resp_valid at cycle 4, hit = 0, addr = 0, multi = 0.
- Write addr 3, data 4'hA → cycle 0 dl = A, dlb = 5; wlwr = 8'b0000_1000 exactly in cycles 1–2; resp_valid at cycle 4; then search A with ml = 8'h08 → hit = 1, addr = 3, multi = 0.
- Write rows 2 and 6; search with ml = 8'hFF → hit = 1, multi = 1, addr = 2 (invalid rows masked).
- Clear, then search with ml = 8'hFF → resp_valid at cycle 0 for the clear; the search returns hit = 0; wlwr, ml_pre and sl stay 0 during the clear.
- Assert rst at write cycle 1 (wlwr high) → wlwr = 0 the next cycle; no resp_valid; a later search on that row returns hit = 0.
- Change req_data/req_addr and pulse req_valid during a search → no effect, no extra acceptance; the assertion that wlwr and ml_pre are never both high, and that dl & dlb are never both 1, holds over 1000 random commands.

Source files
------------

// File: rtl/cam_ctrl.sv
// Command sequencer for the 9T SRAM CAM array: write pulses, match-line precharge/evaluate,
// per-row valid tracking and priority-encoded search results.
module cam_ctrl #(
  parameter int WORDS    = 8,
  parameter int WIDTH    = 4,
  parameter int WR_CYC   = 2,
  parameter int PRE_CYC  = 2,
  parameter int EVAL_CYC = 1,
  localparam int AW      = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic             resp_multi,
  output logic [AW-1:0]    resp_addr,
  output logic [WORDS-1:0] wlwr,
  output logic [WIDTH-1:0] dl,
  output logic [WIDTH-1:0] dlb,
  output logic [WIDTH-1:0] sl,
  output logic [WIDTH-1:0] slb,
  output logic             ml_pre,
  input  logic [WORDS-1:0] ml
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_SETUP = 3'd1;
  localparam logic [2:0] WR_PULSE = 3'd2;
  localparam logic [2:0] WR_HOLD  = 3'd3;
  localparam logic [2:0] S_PRE    = 3'd4;
  localparam logic [2:0] S_EVAL   = 3'd5;
  localparam logic [2:0] S_CAPT   = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  localparam logic [WORDS-1:0] ONE = {{(WORDS-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [7:0]       cnt;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] data_q;
  logic [WORDS-1:0] valid;
  logic [WORDS-1:0] m;
  logic [AW-1:0]    enc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      valid  <= '0;
      m      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            data_q <= req_data;
            cnt    <= '0;
            case (req_op)
              2'b01: state <= WR_SETUP;
              2'b10: state <= S_PRE;
              2'b11: begin
                valid <= '0;
                state <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
        WR_SETUP: begin
          cnt   <= '0;
          state <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == 8'(WR_CYC - 1)) state <= WR_HOLD;
          else cnt <= cnt + 8'd1;
        end
        WR_HOLD: begin
          valid[addr_q] <= 1'b1;
          state         <= DONE;
        end
        S_PRE: begin
          if (cnt == 8'(PRE_CYC - 1)) begin
            cnt   <= '0;
            state <= S_EVAL;
          end else cnt <= cnt + 8'd1;
        end
        S_EVAL: begin
          if (cnt == 8'(EVAL_CYC - 1)) state <= S_CAPT;
          else cnt <= cnt + 8'd1;
        end
        // m holds the last search result until the next capture, so the response
        // fields stay stable across intervening writes and clears.
        S_CAPT: begin
          m     <= ml & valid;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    enc = '0;
    for (int i = WORDS - 1; i >= 0; i--) begin
      if (m[i]) enc = AW'(i);
    end
  end

  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    resp_valid = (state == DONE);
    resp_hit   = |m;
    resp_multi = |(m & (m - ONE));
    resp_addr  = enc;
    wlwr       = (state == WR_PULSE) ? (ONE << addr_q) : '0;
    ml_pre     = (state == S_PRE);
    dl         = '0;
    dlb        = '0;
    sl         = '0;
    slb        = '0;
    if (state == WR_SETUP || state == WR_PULSE || state == WR_HOLD) begin
      dl  = data_q;
      dlb = ~data_q;
    end
    if (state == S_EVAL || state == S_CAPT) begin
      sl  = data_q;
      slb = ~data_q;
    end
  end

endmodule

// File: tb/tb_cam_ctrl.sv
// Scenario-driven bench for cam_ctrl: a behavioural valid/match model feeds a response
// scoreboard, while a monitor checks array-side invariants every cycle.
module tb_cam_ctrl;

  typedef struct packed {
    logic       hit;
    logic       multi;
    logic [2:0] addr;
  } resp_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [2:0] req_addr;
  logic [3:0] req_data;
  logic       resp_valid;
  logic       resp_hit;
  logic       resp_multi;
  logic [2:0] resp_addr;
  logic [7:0] wlwr;
  logic [3:0] dl;
  logic [3:0] dlb;
  logic [3:0] sl;
  logic [3:0] slb;
  logic       ml_pre;
  logic [7:0] ml;

  int    errors = 0;
  int    checks = 0;
  resp_t sb[$];
  logic [7:0] mvalid;
  resp_t      last;

  cam_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_multi(resp_multi),
    .resp_addr(resp_addr), .wlwr(wlwr), .dl(dl), .dlb(dlb), .sl(sl), .slb(slb),
    .ml_pre(ml_pre), .ml(ml)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Response scoreboard and array-side invariants, sampled on the falling edge
  always @(negedge clk) begin
    resp_t exp;
    resp_t got;
    if (!rst && resp_valid === 1'b1) begin
      checks++;
      got = {resp_hit, resp_multi, resp_addr};
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_resp got resp_valid=1 want no response");
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL resp_fields got hit=%0b multi=%0b addr=%0d want hit=%0b multi=%0b addr=%0d",
                   got.hit, got.multi, got.addr, exp.hit, exp.multi, exp.addr);
        end
      end
    end
    checks++;
    if ((wlwr !== 8'h00 && ml_pre !== 1'b0) || (dl & dlb) !== 4'h0 ||
        (ml_pre !== 1'b0 && (sl | slb) !== 4'h0)) begin
      errors++;
      $display("[TB] FAIL invariant got wlwr=%h ml_pre=%b dl=%h dlb=%h sl=%h slb=%h want exclusive drive",
               wlwr, ml_pre, dl, dlb, sl, slb);
    end
  end

  function automatic resp_t model_search(input logic [7:0] mlv);
    resp_t r;
    logic [7:0] mm;
    logic found;
    mm = mlv & mvalid;
    found = 1'b0;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (mm[i] && !found) begin
        r.addr = 3'(i);
        found = 1'b1;
      end
    end
    r.hit = found;
    r.multi = ($countones(mm) > 1);
    return r;
  endfunction

  // Waits for ready, presents one command, and returns at the falling edge of cycle 0
  task automatic issue(input logic [1:0] op, input logic [2:0] addr, input logic [3:0] data,
                       input logic [7:0] mlv);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_timeout got req_ready=%b want 1", req_ready);
    end
    req_op = op; req_addr = addr; req_data = data; ml = mlv; req_valid = 1'b1;
    case (op)
      2'b01: begin sb.push_back(last); mvalid[addr] = 1'b1; end
      2'b10: begin last = model_search(mlv); sb.push_back(last); end
      2'b11: begin mvalid = '0; sb.push_back(last); end
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_timeout got pending=%0d req_ready=%b want 0 and 1", sb.size(), req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_hit, resp_multi, resp_addr, wlwr, dl, dlb, sl, slb, ml_pre} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got ready=%b rv=%b wlwr=%h dl=%h sl=%h ml_pre=%b want all 0",
               req_ready, resp_valid, wlwr, dl, sl, ml_pre);
    end
    rst = 1'b0;
    mvalid = '0;
    last = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got %b want 1", req_ready);
    end
    issue(2'b10, 3'd0, 4'h5, 8'hFF);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (ml_pre !== (k < 2) || sl !== ((k == 2 || k == 3) ? 4'h5 : 4'h0) ||
          slb !== ((k == 2 || k == 3) ? 4'hA : 4'h0) || resp_valid !== (k == 4)) begin
        errors++;
        $display("[TB] FAIL search_timing cycle %0d got ml_pre=%b sl=%h slb=%h rv=%b", k, ml_pre, sl, slb, resp_valid);
      end
    end
    wait_idle();
  endtask

  task automatic test_write();
    issue(2'b01, 3'd3, 4'hA, 8'h00);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (wlwr !== ((k == 1 || k == 2) ? 8'b0000_1000 : 8'h00) || resp_valid !== (k == 4) ||
          dl !== ((k <= 3) ? 4'hA : 4'h0) || dlb !== ((k <= 3) ? 4'h5 : 4'h0)) begin
        errors++;
        $display("[TB] FAIL write_timing cycle %0d got wlwr=%h dl=%h dlb=%h rv=%b", k, wlwr, dl, dlb, resp_valid);
      end
    end
    wait_idle();
    issue(2'b10, 3'd0, 4'hA, 8'h08);
    wait_idle();
  endtask

  task automatic test_multi();
    issue(2'b01, 3'd2, 4'h1, 8'h00); wait_idle();
    issue(2'b01, 3'd6, 4'h7, 8'h00); wait_idle();
    issue(2'b10, 3'd0, 4'h1, 8'hFF);
    wait_idle();
    checks++;
    if ({resp_hit, resp_multi, resp_addr} !== {1'b1, 1'b1, 3'd2}) begin
      errors++;
      $display("[TB] FAIL multi_hold got hit=%b multi=%b addr=%0d want 1 1 2", resp_hit, resp_multi, resp_addr);
    end
  endtask

  task automatic test_clear();
    issue(2'b11, 3'd0, 4'h0, 8'h00);
    checks++;
    if (resp_valid !== 1'b1 || wlwr !== 8'h00 || ml_pre !== 1'b0 || sl !== 4'h0) begin
      errors++;
      $display("[TB] FAIL clear_cycle0 got rv=%b wlwr=%h ml_pre=%b sl=%h want 1 00 0 0", resp_valid, wlwr, ml_pre, sl);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_single_strobe got rv=%b want 0", resp_valid);
    end
    wait_idle();
    issue(2'b10, 3'd0, 4'h1, 8'hFF);
    wait_idle();
  endtask

  task automatic test_reset_abort();
    issue(2'b01, 3'd5, 4'h9, 8'h00);
    @(negedge clk);
    checks++;
    if (wlwr !== 8'b0010_0000) begin
      errors++;
      $display("[TB] FAIL abort_pulse got wlwr=%h want 20", wlwr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wlwr !== 8'h00 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_drop got wlwr=%h rv=%b want 00 0", wlwr, resp_valid);
    end
    sb.delete();
    mvalid = '0;
    last = '0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    issue(2'b10, 3'd0, 4'h9, 8'h20);
    wait_idle();
  endtask

  task automatic test_ignore_inputs();
    issue(2'b01, 3'd4, 4'hC, 8'h00); wait_idle();
    issue(2'b10, 3'd0, 4'hC, 8'h1C);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || dl !== 4'h0 || (k >= 2 && sl !== 4'hC)) begin
        errors++;
        $display("[TB] FAIL ignore_inputs cycle %0d got ready=%b dl=%h sl=%h want 0 0 C", k, req_ready, dl, sl);
      end
      req_valid = (k != 3);
      req_op = 2'b01;
      req_addr = 3'(k);
      req_data = 4'(~k);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_op = 2'b01; req_addr = 3'd1; req_data = 4'h3; req_valid = 1'b1;
    sb.push_back(last);
    sb.push_back(last);
    mvalid[1] = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== (k == 4 || k == 10) || (k == 5 && req_ready !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d got rv=%b ready=%b", k, resp_valid, req_ready);
      end
      if (k == 6) req_valid = 1'b0;
    end
    wait_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom), 4'($urandom), 8'($urandom));
      wait_idle();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = '0;
    req_data = '0;
    ml = '0;
    mvalid = '0;
    last = '0;
    test_reset();
    test_write();
    test_multi();
    test_clear();
    test_reset_abort();
    test_ignore_inputs();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_responses got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
